// File: rtl/write_back_queue_pkg.sv
// rtl/write_back_queue_pkg.sv - shared types and default sizes for the write-back queue
package write_back_queue_pkg;

  localparam int WB_LANES        = 2;
  localparam int WB_PORTS        = 1;
  localparam int WB_DEPTH        = 4;
  localparam int WB_REG_ID_WIDTH = 5;
  localparam int WB_DATA_WIDTH   = 32;

  // Default-width view of one pending register write
  typedef struct packed {
    logic [WB_REG_ID_WIDTH-1:0] regId;
    logic [WB_DATA_WIDTH-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_DRAIN  = 2'd1,
    WB_HALTED = 2'd2
  } wb_state_t;

endpackage

// File: rtl/write_back_lookup.sv
// rtl/write_back_lookup.sv - youngest-match forwarding search over the pending queue
module write_back_lookup
  import write_back_queue_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH,
  parameter int REG_ID_WIDTH = WB_REG_ID_WIDTH,
  parameter int DATA_WIDTH   = WB_DATA_WIDTH
) (
  input  logic [DEPTH-1:0]                   entryValid,
  input  logic [DEPTH-1:0][REG_ID_WIDTH-1:0] entryId,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]   entryData,
  input  logic [REG_ID_WIDTH-1:0]            lookupId,
  output logic                               lookupHit,
  output logic [DATA_WIDTH-1:0]              lookupData
);

  // Entries arrive oldest-first, so the last match scanned is the youngest
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entryValid[k] && (entryId[k] == lookupId) && (lookupId != '0)) begin
        lookupHit  = 1'b1;
        lookupData = entryData[k];
      end
    end
  end

endmodule

// File: rtl/write_back_queue.sv
// rtl/write_back_queue.sv - multi-lane program-ordered write-back queue with drain-then-halt (option: WRITE_BACK_FORWARD_EN)
module write_back_queue
  import write_back_queue_pkg::*;
#(
  parameter int LANES        = WB_LANES,
  parameter int PORTS        = WB_PORTS,
  parameter int DEPTH        = WB_DEPTH,
  parameter int REG_ID_WIDTH = WB_REG_ID_WIDTH,
  parameter int DATA_WIDTH   = WB_DATA_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [LANES-1:0]              in_valid,
  input  logic [LANES-1:0]              in_write_en,
  input  logic [LANES*REG_ID_WIDTH-1:0] in_reg_id,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [LANES-1:0]              in_syscall,
  output logic                          in_ready,
  output logic [PORTS-1:0]              rf_write_en,
  output logic [PORTS*REG_ID_WIDTH-1:0] rf_write_id,
  output logic [PORTS*DATA_WIDTH-1:0]   rf_write_data,
  input  logic [REG_ID_WIDTH-1:0]       lookup_id,
  output logic                          lookup_hit,
  output logic [DATA_WIDTH-1:0]         lookup_data,
  input  logic                          resume,
  output logic                          halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][REG_ID_WIDTH-1:0] entryId;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   entryData;
  logic [PTR_W-1:0]                   headPtr;
  logic [PTR_W-1:0]                   tailPtr;
  logic [CNT_W-1:0]                   count;
  wb_state_t                          state;
  wb_state_t                          stateNext;

  logic [LANES-1:0]                   laneEnq;
  logic [LANES-1:0][PTR_W-1:0]        laneOffset;
  logic [CNT_W-1:0]                   enqCount;
  logic                               syscallSeen;
  logic [CNT_W-1:0]                   retireCount;

  // Age-ordered view: index 0 is the oldest pending entry
  logic [DEPTH-1:0]                   agedValid;
  logic [DEPTH-1:0][REG_ID_WIDTH-1:0] agedId;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   agedData;

  // Pick lanes to enqueue in order, stopping at the first accepted syscall
  always_comb begin
    laneEnq     = '0;
    laneOffset  = '0;
    enqCount    = '0;
    syscallSeen = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      laneOffset[l] = enqCount[PTR_W-1:0];
      if (in_ready && in_valid[l] && !syscallSeen) begin
        if (in_syscall[l]) begin
          syscallSeen = 1'b1;
        end else if (in_write_en[l] && (in_reg_id[l*REG_ID_WIDTH +: REG_ID_WIDTH] != '0)) begin
          laneEnq[l] = 1'b1;
          enqCount   = enqCount + CNT_W'(1);
        end
      end
    end
  end

  assign retireCount = (count < CNT_W'(PORTS)) ? count : CNT_W'(PORTS);

  // Rotate storage so consumers see entries oldest-first
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      agedValid[k] = (CNT_W'(k) < count);
      agedId[k]    = entryId[headPtr + PTR_W'(k)];
      agedData[k]  = entryData[headPtr + PTR_W'(k)];
    end
  end

  // Head group onto the write ports; a younger same-id entry in the group masks older ones
  always_comb begin
    rf_write_en   = '0;
    rf_write_id   = '0;
    rf_write_data = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (agedValid[p]) begin
        rf_write_en[p] = 1'b1;
        rf_write_id[p*REG_ID_WIDTH +: REG_ID_WIDTH] = agedId[p];
        rf_write_data[p*DATA_WIDTH +: DATA_WIDTH]   = agedData[p];
        for (int q = p + 1; q < PORTS; q++) begin
          if (agedValid[q] && (agedId[q] == agedId[p])) begin
            rf_write_en[p] = 1'b0;
          end
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; enqueue and retire may share a cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      headPtr <= headPtr + PTR_W'(retireCount);
      tailPtr <= tailPtr + PTR_W'(enqCount);
      count   <= count - retireCount + enqCount;
    end
  end

  // Entry storage; contents are only meaningful while counted as pending
  always_ff @(posedge clock) begin
    for (int l = 0; l < LANES; l++) begin
      if (laneEnq[l]) begin
        entryId[tailPtr + laneOffset[l]]   <= in_reg_id[l*REG_ID_WIDTH +: REG_ID_WIDTH];
        entryData[tailPtr + laneOffset[l]] <= in_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WB_RUN;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state: syscall drains the queue, then holds until resume
  always_comb begin
    stateNext = state;
    case (state)
      WB_RUN:    if (syscallSeen) stateNext = WB_DRAIN;
      WB_DRAIN:  if (count == '0) stateNext = WB_HALTED;
      WB_HALTED: if (resume)      stateNext = WB_RUN;
      default:   stateNext = WB_RUN;
    endcase
  end

  // FSM outputs; in_ready ignores same-cycle retires so it stays registered-only
  always_comb begin
    in_ready = (state == WB_RUN) && ((CNT_W'(DEPTH) - count) >= CNT_W'(LANES));
    halted   = (state == WB_HALTED);
  end

`ifdef WRITE_BACK_FORWARD_EN
  write_back_lookup #(
    .DEPTH       (DEPTH),
    .REG_ID_WIDTH(REG_ID_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_lookup (
    .entryValid(agedValid),
    .entryId   (agedId),
    .entryData (agedData),
    .lookupId  (lookup_id),
    .lookupHit (lookup_hit),
    .lookupData(lookup_data)
  );
`else
  logic unusedForward;
  assign unusedForward = ^{lookup_id, agedValid, agedId, agedData};
  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_write_back_queue.sv
// tb/tb_write_back_queue.sv - directed self-checking bench for write_back_queue (PORTS=1 and PORTS=2 instances)
module tb_write_back_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  in_valid;
  logic [1:0]  in_write_en;
  logic [9:0]  in_reg_id;
  logic [63:0] in_data;
  logic [1:0]  in_syscall;
  logic [4:0]  lookup_id;
  logic        resume;

  logic        aReady, aHit, aHalted;
  logic [0:0]  aEn;
  logic [4:0]  aId;
  logic [31:0] aData, aLook;
  logic        bReady, bHit, bHalted;
  logic [1:0]  bEn;
  logic [9:0]  bId;
  logic [63:0] bData;
  logic [31:0] bLook;

  int assertCount = 0;
  int failCount   = 0;

  logic [4:0]  logId   [64];
  logic [31:0] logData [64];
  int          logN = 0;

  logic        expHit;
  logic [31:0] expLook;

  write_back_queue #(.PORTS(1)) dutA (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_write_en(in_write_en),
    .in_reg_id(in_reg_id), .in_data(in_data), .in_syscall(in_syscall), .in_ready(aReady),
    .rf_write_en(aEn), .rf_write_id(aId), .rf_write_data(aData),
    .lookup_id(lookup_id), .lookup_hit(aHit), .lookup_data(aLook),
    .resume(resume), .halted(aHalted)
  );

  write_back_queue #(.PORTS(2)) dutB (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_write_en(in_write_en),
    .in_reg_id(in_reg_id), .in_data(in_data), .in_syscall(in_syscall), .in_ready(bReady),
    .rf_write_en(bEn), .rf_write_id(bId), .rf_write_data(bData),
    .lookup_id(lookup_id), .lookup_hit(bHit), .lookup_data(bLook),
    .resume(resume), .halted(bHalted)
  );

  always #5 clock = ~clock;

  // Record every register-file write of the single-port instance
  always @(negedge clock) begin
    if (aEn[0] && logN < 64) begin
      logId[logN]   = aId;
      logData[logN] = aData;
      logN          = logN + 1;
    end
  end

  task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid    = '0;
    in_write_en = '0;
    in_syscall  = '0;
    in_reg_id   = '0;
    in_data     = '0;
  endtask

  task automatic setLane(input int l, input logic we, input logic [4:0] id, input logic [31:0] d, input logic sc);
    in_valid[l]            = 1'b1;
    in_write_en[l]         = we;
    in_reg_id[l*5 +: 5]    = id;
    in_data[l*32 +: 32]    = d;
    in_syscall[l]          = sc;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int t;
    logic sawStall;

`ifdef WRITE_BACK_FORWARD_EN
    expHit  = 1'b1;
    expLook = 32'h2;
`else
    expHit  = 1'b0;
    expLook = 32'h0;
`endif
    resume    = 1'b0;
    lookup_id = 5'd0;
    doReset();

    // Reset state
    checkValue("reset in_ready", aReady, 1);
    checkValue("reset rf_en", aEn, 0);
    checkValue("reset rf_id", aId, 0);
    checkValue("reset rf_data", aData, 0);
    checkValue("reset lookup_hit", aHit, 0);
    checkValue("reset halted", aHalted, 0);
    checkValue("reset b in_ready", bReady, 1);
    checkValue("reset b rf_en", bEn, 0);
    checkValue("reset b halted", bHalted, 0);

    // Two lanes, single port: one write per cycle in lane order
    setLane(0, 1, 5'd3, 32'h11, 0);
    setLane(1, 1, 5'd4, 32'h22, 0);
    tick();
    idle();
    checkValue("t1 c1 en", aEn, 1);
    checkValue("t1 c1 id", aId, 3);
    checkValue("t1 c1 data", aData, 32'h11);
    checkValue("t1 c1 ready", aReady, 1);
    tick();
    checkValue("t1 c2 en", aEn, 1);
    checkValue("t1 c2 id", aId, 4);
    checkValue("t1 c2 data", aData, 32'h22);
    checkValue("t1 c2 ready", aReady, 1);
    tick();
    checkValue("t1 c3 en", aEn, 0);

    // Back-pressure: four dual-write groups through one port
    doReset();
    base     = logN;
    sawStall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      setLane(0, 1, 5'(2*k + 1), 32'h100 + 32'(2*k), 0);
      setLane(1, 1, 5'(2*k + 2), 32'h101 + 32'(2*k), 0);
      t = 0;
      while (!aReady && t < 20) begin
        sawStall = 1'b1;
        tick();
        t++;
      end
      checkValue("t2 ready before accept", aReady, 1);
      tick();
    end
    idle();
    for (int i = 0; i < 10; i++) tick();
    checkValue("t2 stall seen", sawStall, 1);
    checkValue("t2 write count", logN - base, 8);
    for (int i = 0; i < 8; i++) begin
      checkValue("t2 order id", logId[base + i], 5'(i + 1));
      checkValue("t2 order data", logData[base + i], 32'h100 + 32'(i));
    end

    // Same-id collision within a two-port drain group
    doReset();
    setLane(0, 1, 5'd5, 32'hA, 0);
    setLane(1, 1, 5'd5, 32'hB, 0);
    tick();
    idle();
    checkValue("t3 b en", bEn, 2'b10);
    checkValue("t3 b id1", bId[9:5], 5);
    checkValue("t3 b data1", bData[63:32], 32'hB);
    checkValue("t3 a data first", aData, 32'hA);
    tick();
    checkValue("t3 b en after", bEn, 0);
    checkValue("t3 a data second", aData, 32'hB);

    // r0 writes and non-writing lanes never reach the register file
    doReset();
    base = logN;
    setLane(0, 1, 5'd0, 32'h33, 0);
    setLane(1, 0, 5'd9, 32'h44, 0);
    tick();
    idle();
    checkValue("t4 b en", bEn, 0);
    tick();
    tick();
    checkValue("t4 no writes", logN - base, 0);
    checkValue("t4 ready", aReady, 1);

    // Syscall with two entries pending: younger lane dropped, drain, halt, resume
    doReset();
    base = logN;
    setLane(0, 1, 5'd1, 32'h55, 0);
    setLane(1, 1, 5'd2, 32'h66, 0);
    tick();
    idle();
    setLane(0, 0, 5'd0, 32'h0, 1);
    setLane(1, 1, 5'd6, 32'h77, 0);
    checkValue("t5 ready at syscall", aReady, 1);
    tick();
    idle();
    checkValue("t5 ready in drain", aReady, 0);
    checkValue("t5 not yet halted", aHalted, 0);
    t = 0;
    while (!aHalted && t < 20) begin
      tick();
      t++;
    end
    checkValue("t5 halted", aHalted, 1);
    checkValue("t5 ready halted", aReady, 0);
    checkValue("t5 drained count", logN - base, 2);
    checkValue("t5 drained id0", logId[base], 1);
    checkValue("t5 drained id1", logId[base + 1], 2);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checkValue("t5 resumed halted", aHalted, 0);
    checkValue("t5 resumed ready", aReady, 1);

    // Reset while draining returns straight to RUN with an empty queue
    doReset();
    setLane(0, 1, 5'd1, 32'h1, 0);
    setLane(1, 1, 5'd2, 32'h2, 0);
    tick();
    idle();
    setLane(0, 0, 5'd0, 32'h0, 1);
    tick();
    idle();
    checkValue("t5b draining", aReady, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkValue("t5b ready", aReady, 1);
    checkValue("t5b rf_en", aEn, 0);
    checkValue("t5b halted", aHalted, 0);

    // Forwarding: youngest pending entry wins, current inputs never hit
    doReset();
    setLane(0, 1, 5'd7, 32'h1, 0);
    setLane(1, 1, 5'd7, 32'h2, 0);
    lookup_id = 5'd7;
    #1;
    checkValue("t6 no hit on inputs", aHit, 0);
    tick();
    idle();
    checkValue("t6 hit", aHit, expHit);
    checkValue("t6 data", aLook, expLook);
    checkValue("t6 b hit", bHit, expHit);
    checkValue("t6 b data", bLook, expLook);
    lookup_id = 5'd0;
    #1;
    checkValue("t6 id0 no hit", aHit, 0);
    lookup_id = 5'd7;
    tick();
    checkValue("t6 hit after one retire", aHit, expHit);
    checkValue("t6 data after one retire", aLook, expLook);
    tick();
    checkValue("t6 hit after drain", aHit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
